div512_seq: RTL and testbench

Sequential 512-bit block-sliced divider, the inverse companion to the ALU multiplier. It takes a dividend slice and a divisor slice, selected by 16-bit block size and offsets, and computes quotient and remainder by radix-2 restoring division. The quotient is written back into the dividend word at the dividend's offset, and the remainder is returned right-aligned. It sits beside the ALU on the same operand buses and uses the same start/ready handshake, so the core sequences it exactly like OP_MUL.

---
 rtl/div512_seq.sv | 202 ++++++++++++++++++++
 tb/tb_div512_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/div512_seq.sv
`default_nettype none
// ============================================================================
// Module   : div512_seq
// Purpose  : Sequential block-sliced radix-2 restoring divider. Divides a
//            16-bit-block slice of in1 by a slice of in2, writes the quotient
//            back into in1 at the dividend offset and returns the remainder
//            right-aligned. Shares the ALU start/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module div512_seq #(
    parameter int WORD_SIZE   = 512,
    parameter int BLOCK_COUNT = 32,
    parameter int OP_SIZE     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] in1,
    input  logic [WORD_SIZE-1:0] in2,
    input  logic [OP_SIZE-1:0]   op_size,
    input  logic [OP_SIZE-1:0]   op_offset1,
    input  logic [OP_SIZE-1:0]   op_offset2,
    input  logic                 signed_op,
    input  logic                 start,
    output logic                 ready,
    output logic [WORD_SIZE-1:0] res,
    output logic [WORD_SIZE-1:0] remainder,
    output logic                 div_zero,
    output logic                 zero
);

    localparam int c_BLK_W = WORD_SIZE / BLOCK_COUNT;   // bits per block
    localparam int c_SH_W  = $clog2(WORD_SIZE);         // bit-position width
    localparam int c_CNT_W = c_SH_W + 1;                // holds WORD_SIZE itself

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_SH_W-1:0]    r_msb;      // nbits-1 of the latched operation
    logic [c_SH_W-1:0]    r_sh1;      // dividend / write-back bit offset
    logic [WORD_SIZE-1:0] r_nmask;    // nbits of ones, right-aligned
    logic [WORD_SIZE-1:0] r_mask1;    // nbits of ones at the dividend offset
    logic [WORD_SIZE-1:0] r_in1;
    logic [WORD_SIZE-1:0] r_a;        // raw dividend slice
    logic [WORD_SIZE-1:0] r_bmag;     // divisor magnitude
    logic [WORD_SIZE-1:0] r_q;
    // The partial remainder is always below |b| < 2^WORD_SIZE, so only the
    // shifted trial value needs the extra bit; the stored remainder does not.
    logic [WORD_SIZE-1:0] r_rem;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_dz;

    // Operand extraction from the live input buses
    logic [c_CNT_W-1:0]   w_nbits;
    logic [c_SH_W-1:0]    w_msb;
    logic [c_SH_W-1:0]    w_sh1;
    logic [c_SH_W-1:0]    w_sh2;
    logic [WORD_SIZE-1:0] w_nmask;
    logic [WORD_SIZE-1:0] w_mask1;
    logic [WORD_SIZE-1:0] w_mask2;
    logic [WORD_SIZE-1:0] w_a;
    logic [WORD_SIZE-1:0] w_b;
    logic                 w_sa;
    logic                 w_sb;
    logic [WORD_SIZE-1:0] w_amag;
    logic [WORD_SIZE-1:0] w_bmag;

    // Iteration datapath
    logic                 w_qbit;
    logic [WORD_SIZE:0]   w_t;
    logic                 w_ge;
    logic [WORD_SIZE-1:0] w_diff;
    logic [WORD_SIZE-1:0] w_qsh;

    // Final fix-up datapath
    logic [WORD_SIZE-1:0] w_qf;
    logic [WORD_SIZE-1:0] w_rf;
    logic [WORD_SIZE-1:0] w_res;

    // Slice masks, operand slices and their magnitudes for a new request
    always_comb begin
        w_nbits = (c_CNT_W'(op_size) + c_CNT_W'(1)) * c_CNT_W'(c_BLK_W);
        w_msb   = c_SH_W'(w_nbits - c_CNT_W'(1));
        w_sh1   = c_SH_W'(op_offset1) * c_SH_W'(c_BLK_W);
        w_sh2   = c_SH_W'(op_offset2) * c_SH_W'(c_BLK_W);
        // A full-width shift yields zero, so op_size=max gives all ones.
        w_nmask = ~({WORD_SIZE{1'b1}} << w_nbits);
        // Blocks pushed past the top of the word simply fall off.
        w_mask1 = w_nmask << w_sh1;
        w_mask2 = w_nmask << w_sh2;
        w_a     = (in1 & w_mask1) >> w_sh1;
        w_b     = (in2 & w_mask2) >> w_sh2;
        w_sa    = signed_op & w_a[w_msb];
        w_sb    = signed_op & w_b[w_msb];
        w_amag  = w_sa ? ((~w_a + WORD_SIZE'(1)) & w_nmask) : w_a;
        w_bmag  = w_sb ? ((~w_b + WORD_SIZE'(1)) & w_nmask) : w_b;
    end

    // One restoring-division step: shift in the next dividend bit and subtract
    always_comb begin
        w_qbit = r_q[r_msb];
        w_t    = {r_rem, w_qbit};
        w_ge   = (w_t >= {1'b0, r_bmag});
        w_diff = w_t[WORD_SIZE-1:0] - r_bmag;
        w_qsh  = (r_q << 1) & r_nmask;
    end

    // Sign correction, divide-by-zero substitution and quotient write-back
    always_comb begin
        if (r_dz) begin
            w_qf = r_nmask;
            w_rf = r_a;
        end else begin
            w_qf = r_neg_q ? ((~r_q + WORD_SIZE'(1)) & r_nmask) : r_q;
            w_rf = r_neg_r ? ((~r_rem + WORD_SIZE'(1)) & r_nmask) : r_rem;
        end
        w_res = (r_in1 & ~r_mask1) | ((w_qf << r_sh1) & r_mask1);
    end

    // Control FSM with latched operands and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_msb     <= '0;
            r_sh1     <= '0;
            r_nmask   <= '0;
            r_mask1   <= '0;
            r_in1     <= '0;
            r_a       <= '0;
            r_bmag    <= '0;
            r_q       <= '0;
            r_rem     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            ready     <= 1'b1;
            res       <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_msb   <= w_msb;
                        r_sh1   <= w_sh1;
                        r_nmask <= w_nmask;
                        r_mask1 <= w_mask1;
                        r_in1   <= in1;
                        r_a     <= w_a;
                        r_bmag  <= w_bmag;
                        r_rem   <= '0;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        ready   <= 1'b0;
                        r_state <= S_DIV;
                        if (w_b == '0) begin
                            // No iterations needed; one idle DIV cycle keeps
                            // the divide-by-zero retire time at two cycles.
                            r_dz    <= 1'b1;
                            r_count <= c_CNT_W'(1);
                            r_q     <= '0;
                        end else begin
                            r_dz    <= 1'b0;
                            r_count <= w_nbits;
                            r_q     <= w_amag;
                        end
                    end
                end
                S_DIV: begin
                    if (!r_dz) begin
                        r_q   <= w_qsh | {{(WORD_SIZE-1){1'b0}}, w_ge};
                        r_rem <= w_ge ? w_diff : w_t[WORD_SIZE-1:0];
                    end
                    r_count <= r_count - c_CNT_W'(1);
                    if (r_count == c_CNT_W'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    res       <= w_res;
                    remainder <= w_rf;
                    div_zero  <= r_dz;
                    zero      <= (w_qf == '0);
                    ready     <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div512_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_div512_seq
// Purpose  : Self-checking bench for div512_seq: directed cases plus random
//            operations compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div512_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] in1;
    logic [511:0] in2;
    logic [4:0]   op_size;
    logic [4:0]   op_offset1;
    logic [4:0]   op_offset2;
    logic         signed_op;
    logic         start;
    logic         ready;
    logic [511:0] res;
    logic [511:0] remainder;
    logic         div_zero;
    logic         zero;

    int n_vec = 0;
    int n_err = 0;

    div512_seq #(
        .WORD_SIZE   (512),
        .BLOCK_COUNT (32),
        .OP_SIZE     (5)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in1        (in1),
        .in2        (in2),
        .op_size    (op_size),
        .op_offset1 (op_offset1),
        .op_offset2 (op_offset2),
        .signed_op  (signed_op),
        .start      (start),
        .ready      (ready),
        .res        (res),
        .remainder  (remainder),
        .div_zero   (div_zero),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: block-wise slice extraction, then plain / and % on magnitudes
    function automatic void ref_div(
        input  logic [511:0] x1, input logic [511:0] x2,
        input  logic [4:0] sz, input logic [4:0] o1, input logic [4:0] o2,
        input  logic sgn,
        output logic [511:0] e_res, output logic [511:0] e_rem,
        output logic e_dz, output logic e_zero);
        int nblk;
        int nb;
        logic [511:0] a, b, lim, am, bm, q, r;
        logic na, nbs;
        nblk = int'(sz) + 1;
        nb   = nblk * 16;
        a = '0;
        b = '0;
        for (int i = 0; i < nblk; i++) begin
            if (int'(o1) + i < 32) a[i*16 +: 16] = x1[(int'(o1)+i)*16 +: 16];
            if (int'(o2) + i < 32) b[i*16 +: 16] = x2[(int'(o2)+i)*16 +: 16];
        end
        lim = (512'(1) << nb) - 512'(1);
        if (b == '0) begin
            q = lim;
            r = a;
        end else begin
            na  = sgn && a[nb-1];
            nbs = sgn && b[nb-1];
            am  = na  ? ((512'(0) - a) & lim) : a;
            bm  = nbs ? ((512'(0) - b) & lim) : b;
            q   = am / bm;
            r   = am % bm;
            if (na != nbs) q = (512'(0) - q) & lim;
            if (na)        r = (512'(0) - r) & lim;
        end
        e_res = x1;
        for (int i = 0; i < nblk; i++) begin
            if (int'(o1) + i < 32) e_res[(int'(o1)+i)*16 +: 16] = q[i*16 +: 16];
        end
        e_rem  = r;
        e_dz   = (b == '0);
        e_zero = (q == '0);
    endfunction

    // Issue one operation, optionally re-pulse start at cycle 'poke', check all
    task automatic run_op(input logic [511:0] x1, input logic [511:0] x2,
                          input logic [4:0] sz, input logic [4:0] o1, input logic [4:0] o2,
                          input logic sgn, input int poke, input string tag);
        logic [511:0] e_res, e_rem;
        logic e_dz, e_zero;
        int cyc;
        int exp_lat;
        ref_div(x1, x2, sz, o1, o2, sgn, e_res, e_rem, e_dz, e_zero);
        exp_lat = e_dz ? 2 : (int'(sz) + 1) * 16 + 1;
        @(negedge clk);
        in1 = x1; in2 = x2; op_size = sz; op_offset1 = o1; op_offset2 = o2;
        signed_op = sgn; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Inputs after acceptance must not influence the result
        in1 = {16{$urandom}};
        in2 = {16{$urandom}};
        op_size = 5'($urandom); op_offset1 = 5'($urandom); op_offset2 = 5'($urandom);
        signed_op = 1'($urandom);
        check({tag, ".busy"}, 512'(ready), 512'(0));
        cyc = 0;
        while (!ready && cyc < 600) begin
            @(posedge clk);
            #1;
            cyc++;
            if (poke > 0) start = (cyc == poke);
        end
        start = 1'b0;
        check({tag, ".latency"}, 512'(cyc), 512'(exp_lat));
        check({tag, ".res"}, res, e_res);
        check({tag, ".rem"}, remainder, e_rem);
        check({tag, ".dz"}, 512'(div_zero), 512'(e_dz));
        check({tag, ".zero"}, 512'(zero), 512'(e_zero));
    endtask

    initial begin
        logic [511:0] x1, x2;
        logic [4:0] sz;

        rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
        op_size = '0; op_offset1 = '0; op_offset2 = '0; signed_op = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", 512'(ready), 512'(1));
        check("rst.res", res, '0);
        check("rst.rem", remainder, '0);
        check("rst.flags", {510'(0), div_zero, zero}, '0);
        rst = 1'b0;

        // Unsigned 100/7 with upper bits passed through
        x1 = {16{32'hDEADBEEF}};
        x1[15:0] = 16'd100;
        x2 = '0;
        x2[15:0] = 16'd7;
        run_op(x1, x2, 5'd0, 5'd0, 5'd0, 1'b0, 0, "u100_7");
        check("u100_7.q16", 512'(res[15:0]), 512'(14));
        check("u100_7.r", remainder, 512'(2));

        // Signed: -7/2 and the overflow case -32768/-1
        x1 = '0; x1[15:0] = 16'hFFF9;
        x2 = '0; x2[15:0] = 16'h0002;
        run_op(x1, x2, 5'd0, 5'd0, 5'd0, 1'b1, 0, "s_m7_2");
        check("s_m7_2.q16", 512'(res[15:0]), 512'(16'hFFFD));
        x1 = '0; x1[15:0] = 16'h8000;
        x2 = '0; x2[15:0] = 16'hFFFF;
        run_op(x1, x2, 5'd0, 5'd0, 5'd0, 1'b1, 0, "s_ovf");
        check("s_ovf.q16", 512'(res[15:0]), 512'(16'h8000));

        // Non-zero offsets
        x1 = {32{16'hAAAA}};
        x1[3*16 +: 16] = 16'h0064;
        x2 = '0;
        x2[5*16 +: 16] = 16'h0007;
        run_op(x1, x2, 5'd0, 5'd3, 5'd5, 1'b0, 0, "offs");
        check("offs.blk3", 512'(res[3*16 +: 16]), 512'(16'h000E));

        // Divide by zero, two-block operand, in both signedness modes
        x1 = '0; x1[31:0] = 32'h0001_2345;
        x2 = {32{16'h5A5A}};
        x2[31:0] = 32'h0;
        run_op(x1, x2, 5'd1, 5'd0, 5'd0, 1'b0, 0, "dz_u");
        check("dz_u.q32", 512'(res[31:0]), 512'(32'hFFFF_FFFF));
        run_op(x1, x2, 5'd1, 5'd0, 5'd0, 1'b1, 0, "dz_s");

        // Full width all-ones / 3
        run_op('1, 512'(3), 5'd31, 5'd0, 5'd0, 1'b0, 0, "full");
        check("full.q", res, {128{4'h5}});

        // Extra start mid-operation must be ignored
        x1 = '0; x1[15:0] = 16'd1000;
        x2 = '0; x2[15:0] = 16'd33;
        run_op(x1, x2, 5'd0, 5'd0, 5'd0, 1'b0, 5, "poke");

        // Reset mid-operation clears everything
        @(negedge clk);
        in1 = '0; in1[15:0] = 16'd500; in2 = '0; in2[15:0] = 16'd9;
        op_size = 5'd0; op_offset1 = 5'd0; op_offset2 = 5'd0; signed_op = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst.ready", 512'(ready), 512'(1));
        check("midrst.res", res, '0);
        check("midrst.rem", remainder, '0);
        check("midrst.flags", {510'(0), div_zero, zero}, '0);
        run_op(x1, x2, 5'd0, 5'd0, 5'd0, 1'b0, 0, "after_rst");

        // Random operations
        for (int k = 0; k < 24; k++) begin
            x1 = {16{$urandom}};
            x2 = {16{$urandom}};
            sz = (k % 8 == 7) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 5));
            if (k % 6 == 2) x2 = '0;
            if (k % 5 == 1) x2 = 512'($urandom_range(1, 40)) << (16 * $urandom_range(0, 31));
            run_op(x1, x2, sz, 5'($urandom), 5'($urandom), 1'($urandom), 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
